// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants for the asynchronous FIFO (write side, read side, memory).
//   DATASIZE : default data word width
//   ADDRSIZE : default RAM address width (depth = 2**ADDRSIZE)
//   PTRSIZE  : Gray/binary pointer width, one extra bit to tell full from empty
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DATASIZE = 32;
  localparam int ADDRSIZE = 6;
  localparam int PTRSIZE  = ADDRSIZE + 1;

endpackage : fifo_pkg

// File: rtl/fifo_rd_ctrl_chk.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl_chk
// Property checker for fifo_rd_ctrl; observes the block's ports only.
// Ports: all inputs, mirroring the fifo_rd_ctrl interface.
// -----------------------------------------------------------------------------
module fifo_rd_ctrl_chk
  import fifo_pkg::*;
#(
  parameter int DATASIZE = fifo_pkg::DATASIZE,
  parameter int ADDRSIZE = fifo_pkg::ADDRSIZE
) (
  input logic                rclk,
  input logic                rrst_n,
  input logic                rclken,
  input logic                rempty,
  input logic [DATASIZE-1:0] dout,
  input logic                dout_valid,
  input logic                dout_ready,
  input logic                rflush
);

  // Never read an empty RAM.
  a_no_fetch_when_empty : assert property (
    @(posedge rclk) disable iff (!rrst_n) rclken |-> !rempty);

  // Flush always wins over a fetch.
  a_flush_blocks_fetch : assert property (
    @(posedge rclk) disable iff (!rrst_n) rflush |-> !rclken);

  // A stalled word stays put until it is taken or flushed.
  a_dout_stable : assert property (
    @(posedge rclk) disable iff (!rrst_n)
      (dout_valid && !dout_ready && !rflush) |=> (dout_valid && $stable(dout)));

endmodule : fifo_rd_ctrl_chk

// File: rtl/gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Purely combinational Gray-to-binary converter, shared by both FIFO sides.
// Ports:
//   gray : Gray-coded input, WIDTH bits
//   bin  : binary equivalent, WIDTH bits
// -----------------------------------------------------------------------------
module gray2bin
  import fifo_pkg::*;
#(
  parameter int WIDTH = PTRSIZE
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Binary bit i is the XOR of every Gray bit at position i and above.
  always_comb begin
    bin = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule : gray2bin

// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side controller of an asynchronous FIFO, entirely in the rclk domain.
// Owns the read pointer, the empty / almost-empty / level flags and a single
// output register in front of the consumer (valid/ready handshake).
// Ports:
//   rclk, rrst_n   : read clock, asynchronous active-low reset
//   rq2_wptr       : write pointer (Gray), already synchronised into rclk
//   rdata          : combinational read data from fifomem
//   raddr, rclken  : RAM read address and read enable (fetch cycle)
//   rptr           : registered Gray read pointer for the write-side sync
//   rempty         : no unfetched word in the RAM
//   ralmost_empty  : rlevel <= AE_THRESH
//   rlevel         : unfetched RAM entries, 0 .. 2**ADDRSIZE
//   dout, dout_valid, dout_ready : output register and its handshake
//   rflush         : synchronous discard of all pending read-side data
// -----------------------------------------------------------------------------
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATASIZE  = fifo_pkg::DATASIZE,
  parameter int ADDRSIZE  = fifo_pkg::ADDRSIZE,
  parameter int AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DATASIZE-1:0] rdata,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                rclken,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  input  logic                rflush
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_LEVEL = PW'(AE_THRESH);

  logic [PW-1:0]       rbin_r;
  logic [PW-1:0]       rptr_r;
  logic                rempty_r;
  logic                ralmost_empty_r;
  logic [PW-1:0]       rlevel_r;
  logic [DATASIZE-1:0] dout_r;
  logic                dout_valid_r;

  logic [PW-1:0]       wbin_s;
  logic                fetch_s;
  logic [PW-1:0]       rbinnext_s;
  logic [PW-1:0]       rgraynext_s;
  logic [PW-1:0]       level_s;

  gray2bin #(
    .WIDTH (PW)
  ) u_wptr_g2b (
    .gray (rq2_wptr),
    .bin  (wbin_s)
  );

  // Fetch decision and next-pointer arithmetic. Only the registered empty flag
  // gates the fetch, so rq2_wptr never reaches rclken combinationally.
  always_comb begin
    fetch_s     = 1'b0;
    rbinnext_s  = rbin_r;
    rgraynext_s = rbin_r ^ (rbin_r >> 1);
    level_s     = {PW{1'b0}};

    fetch_s = !rempty_r && (!dout_valid_r || dout_ready) && !rflush;

    if (rflush) begin
      rbinnext_s = wbin_s;
    end else begin
      rbinnext_s = rbin_r + {{(PW-1){1'b0}}, fetch_s};
    end

    rgraynext_s = rbinnext_s ^ (rbinnext_s >> 1);
    // Modulo-2**PW subtraction; the extra MSB makes a wrapped writer still
    // yield the right distance (up to a full RAM).
    level_s     = wbin_s - rbinnext_s;
  end

  // Read pointer and flag registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_r          <= {PW{1'b0}};
      rptr_r          <= {PW{1'b0}};
      rempty_r        <= 1'b1;
      ralmost_empty_r <= 1'b1;
      rlevel_r        <= {PW{1'b0}};
    end else begin
      rbin_r          <= rbinnext_s;
      rptr_r          <= rgraynext_s;
      rempty_r        <= (rgraynext_s == rq2_wptr);
      ralmost_empty_r <= (level_s <= AE_LEVEL);
      rlevel_r        <= level_s;
    end
  end

  // Output register: flush drops the word, a fetch loads the RAM word the
  // same cycle, otherwise the word leaves on a handshake or is held.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      dout_r       <= {DATASIZE{1'b0}};
      dout_valid_r <= 1'b0;
    end else if (rflush) begin
      dout_r       <= dout_r;
      dout_valid_r <= 1'b0;
    end else if (fetch_s) begin
      dout_r       <= rdata;
      dout_valid_r <= 1'b1;
    end else begin
      dout_r       <= dout_r;
      dout_valid_r <= dout_valid_r && !dout_ready;
    end
  end

  // raddr comes straight from the registered pointer; it is 0 in reset.
  assign raddr         = rbin_r[ADDRSIZE-1:0];
  assign rclken        = fetch_s;
  assign rptr          = rptr_r;
  assign rempty        = rempty_r;
  assign ralmost_empty = ralmost_empty_r;
  assign rlevel        = rlevel_r;
  assign dout          = dout_r;
  assign dout_valid    = dout_valid_r;

endmodule : fifo_rd_ctrl

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
// Random writer / consumer around fifo_rd_ctrl (ADDRSIZE=4, AE_THRESH=2).
// The bench plays fifomem and the write side; a count-based model predicts
// every output cycle by cycle.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AE    = 2;
  localparam int NCYC  = 3000;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic [AW:0]   rq2_wptr;
  logic [DW-1:0] rdata;
  logic [AW-1:0] raddr;
  logic          rclken;
  logic [AW:0]   rptr;
  logic          rempty;
  logic          ralmost_empty;
  logic [AW:0]   rlevel;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          rflush;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] log_mem [256];

  int tests_run = 0;
  int tests_failed = 0;

  // model state: absolute counts of words written and fetched
  int            m_w;
  int            m_rd;
  int            m_seen;   // unfetched words as seen at the last edge
  bit            m_ov;
  logic [DW-1:0] m_od;

  always #5 rclk = ~rclk;

  assign rdata = mem[raddr];

  fifo_rd_ctrl #(
    .DATASIZE  (DW),
    .ADDRSIZE  (AW),
    .AE_THRESH (AE)
  ) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rq2_wptr      (rq2_wptr),
    .rdata         (rdata),
    .raddr         (raddr),
    .rclken        (rclken),
    .rptr          (rptr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .rflush        (rflush)
  );

  fifo_rd_ctrl_chk #(
    .DATASIZE (DW),
    .ADDRSIZE (AW)
  ) u_chk (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rclken     (rclken),
    .rempty     (rempty),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .rflush     (rflush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW:0] to_gray(input int v);
    logic [AW:0] b;
    b = v[AW:0];
    return b ^ (b >> 1);
  endfunction

  function automatic bit model_fetch();
    return (m_seen > 0) && (!m_ov || dout_ready) && !rflush;
  endfunction

  task automatic model_reset();
    m_w = 0; m_rd = 0; m_seen = 0; m_ov = 1'b0; m_od = '0;
  endtask

  // one rclk edge of the read side, in terms of word counts
  task automatic model_edge();
    bit f;
    f = model_fetch();
    if (rflush) begin
      m_rd = m_w;
      m_ov = 1'b0;
    end else if (f) begin
      m_od = log_mem[m_rd % 256];
      m_ov = 1'b1;
      m_rd++;
    end else if (dout_ready) begin
      m_ov = 1'b0;
    end
    m_seen = m_w - m_rd;
  endtask

  task automatic check_regs(input string pfx);
    check({pfx, "_rempty"}, 32'(rempty),        32'(m_seen == 0));
    check({pfx, "_rlevel"}, 32'(rlevel),        32'(m_seen));
    check({pfx, "_ae"},     32'(ralmost_empty), 32'(m_seen <= AE));
    check({pfx, "_rptr"},   32'(rptr),          32'(to_gray(m_rd)));
    check({pfx, "_dvalid"}, 32'(dout_valid),    32'(m_ov));
    check({pfx, "_dout"},   dout,               m_od);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_rempty"}, 32'(rempty),        32'd1);
    check({pfx, "_ae"},     32'(ralmost_empty), 32'd1);
    check({pfx, "_rlevel"}, 32'(rlevel),        32'd0);
    check({pfx, "_rptr"},   32'(rptr),          32'd0);
    check({pfx, "_dvalid"}, 32'(dout_valid),    32'd0);
    check({pfx, "_dout"},   dout,               32'd0);
    check({pfx, "_raddr"},  32'(raddr),         32'd0);
    check({pfx, "_rclken"}, 32'(rclken),        32'd0);
  endtask

  // write up to k words, never more than the RAM can hold unfetched
  task automatic writer(input int k);
    int space;
    space = DEPTH - (m_w - m_rd);
    if (k > space) k = space;
    for (int i = 0; i < k; i++) begin
      logic [DW-1:0] d;
      d = $urandom;
      mem[m_w % DEPTH]   = d;
      log_mem[m_w % 256] = d;
      m_w++;
    end
    rq2_wptr = to_gray(m_w);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int i = 0; i < 256; i++) log_mem[i] = '0;
    model_reset();
    rrst_n     = 1'b0;
    rq2_wptr   = '0;
    dout_ready = 1'b0;
    rflush     = 1'b0;

    repeat (2) @(negedge rclk);
    check_reset_vals("reset");
    rrst_n = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      int k;
      // phase-dependent traffic
      k = $urandom_range(0, 3);
      if (k == 3) k = 0;
      if (cyc >= 600 && cyc < 800) k = ($urandom_range(0, 15) == 0) ? 1 : 0;
      if (cyc < 200) begin
        dout_ready = 1'b1;
        rflush     = 1'b0;
      end else if (cyc < 400) begin
        dout_ready = ($urandom_range(0, 11) == 0);
        rflush     = 1'b0;
      end else begin
        dout_ready = ($urandom_range(0, 3) != 0);
        rflush     = ($urandom_range(0, 39) == 0);
      end
      writer(k);

      #1;
      check("rclken", 32'(rclken), 32'(model_fetch()));
      check("raddr",  32'(raddr),  32'(m_rd % DEPTH));

      @(posedge rclk);
      model_edge();

      if (cyc == 1500 || cyc == 2500) begin
        // asynchronous reset in the middle of streaming
        #3;
        rrst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        model_reset();
        @(negedge rclk);
        rq2_wptr   = '0;
        rflush     = 1'b0;
        dout_ready = 1'b0;
        @(negedge rclk);
        rrst_n = 1'b1;
      end else begin
        @(negedge rclk);
        check_regs("cyc");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_fifo_rd_ctrl

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 The module SHALL have parameter DATASIZE, default 32, meaning the data word width; it must match fifomem.
REQ-002 The module SHALL have parameter ADDRSIZE, default 6, meaning the RAM address width; RAM depth is 2^ADDRSIZE and pointers are ADDRSIZE+1 bits.
REQ-003 The module SHALL have parameter AE_THRESH, default 2, meaning the almost-empty threshold in entries.
REQ-004 The module SHALL have rclk, input, 1 bit: the read-domain clock; this is the only clock.
REQ-005 The module SHALL have rrst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The module SHALL have rq2_wptr, input, ADDRSIZE+1 bits: the write pointer, Gray-coded, already 2-flop synchronised into rclk.
REQ-007 The module SHALL have rdata, input, DATASIZE bits: the combinational read data from fifomem.
REQ-008 The module SHALL have raddr, output, ADDRSIZE bits: the RAM read address.
REQ-009 The module SHALL have rclken, output, 1 bit: the RAM read enable, asserted on a fetch cycle.
REQ-010 The module SHALL have rptr, output, ADDRSIZE+1 bits: the registered Gray read pointer, sent to the write-domain synchroniser.
REQ-011 The module SHALL have rempty, output, 1 bit: registered; the RAM holds no unfetched word.
REQ-012 The module SHALL have ralmost_empty, output, 1 bit: registered; rlevel <= AE_THRESH.
REQ-013 The module SHALL have rlevel, output, ADDRSIZE+1 bits: the registered count of unfetched RAM entries, range 0..2^ADDRSIZE.
REQ-014 The module SHALL have dout, output, DATASIZE bits: the output register data.
REQ-015 The module SHALL have dout_valid, output, 1 bit: the output register holds a word.
REQ-016 The module SHALL have dout_ready, input, 1 bit: the consumer accepts dout this cycle.
REQ-017 The module SHALL have rflush, input, 1 bit: a synchronous discard of all pending read-side data.

Function
REQ-018 Definitions: rbin is the binary read pointer, ADDRSIZE+1 bits; wbin_s is gray2bin(rq2_wptr); raddr is rbin[ADDRSIZE-1:0].
REQ-019 Fetch condition: fetch = !rempty & (!dout_valid | dout_ready) & !rflush; rclken = fetch.
REQ-020 On a fetch: dout <= rdata, captured the same cycle because fifomem read is combinational; dout_valid <= 1; rbin <= rbin+1.
REQ-021 Without a fetch: dout_valid <= dout_valid & !dout_ready, and dout holds its value.
REQ-022 Output-register latency: a word present with rempty=0 and an empty output register SHALL appear on dout exactly 1 cycle later.
REQ-023 The output register SHALL sustain 1 word per cycle when dout_ready=1 continuously.
REQ-024 Handshake: a transfer occurs when dout_valid & dout_ready; dout SHALL stay stable while dout_valid & !dout_ready.
REQ-025 Next-pointer computation: rbinnext = rflush ? wbin_s : rbin+fetch, and rgraynext = rbinnext ^ (rbinnext>>1).
REQ-026 On each clock: rptr <= rgraynext and rempty <= (rgraynext == rq2_wptr).
REQ-027 Level: rlevel <= wbin_s - rbinnext, computed modulo 2^(ADDRSIZE+1); the wrap of the MSB SHALL yield the correct count.
REQ-028 Almost-empty: ralmost_empty <= ((wbin_s - rbinnext) <= AE_THRESH).
REQ-029 Wrap-around: when rbin goes from 2^ADDRSIZE-1 to 2^ADDRSIZE, raddr SHALL return to 0 and the rptr MSB SHALL toggle.
REQ-030 Flush: rflush has priority over a fetch; the next cycle SHALL show dout_valid=0, rempty=1, rlevel=0, rptr=rq2_wptr and no rclken.
REQ-031 Simultaneous write arrival and empty: rempty SHALL deassert only on the registered compare, so there is no combinational path from rq2_wptr to rclken.
REQ-032 Writer stall: no fetch SHALL occur while rempty=1, whatever the value of dout_ready.

Reset
REQ-033 While rrst_n=0, asynchronously: rbin=0, rptr=0, rempty=1, ralmost_empty=1, rlevel=0, dout_valid=0, dout=0.
REQ-034 Because raddr=0 and rclken=0 during reset, reset asserted mid-transfer SHALL discard the output word.
REQ-035 Reset release SHALL be synchronous to rclk through the external reset synchroniser; the block adds no extra sequencing.

Structure
REQ-036 The default DATASIZE and ADDRSIZE values SHALL live in the shared FIFO package fifo_pkg, together with the Gray and binary pointer width constant PTRSIZE = ADDRSIZE+1.
REQ-037 The Gray-to-binary conversion SHALL be a sub-module gray2bin, with parameter width, that the write side also reuses.
REQ-038 All registers in the block SHALL sit in rclk; the block SHALL contain no memory.

Verification (ADDRSIZE=4, AE_THRESH=2)
REQ-039 Reset: rrst_n=0 -> rempty=1, dout_valid=0, rptr=5'b00000, rlevel=0, raddr=0, rclken=0.
REQ-040 Drain: rq2_wptr=gray(3)=5'b00010, dout_ready=1 -> fetches at raddr 0, 1, 2 on consecutive cycles, then rempty=1 and rptr=5'b00010.
REQ-041 Backpressure: rq2_wptr=gray(5), dout_ready=0 -> exactly one fetch, rlevel=4, and dout held stable for 10 cycles.
REQ-042 Wrap: rbin=15, wbin_s=18 -> raddr sequence 15, 0, 1; rptr goes 01000 -> 11000 -> 11001; rlevel 3 -> 2 -> 1.
REQ-043 Flush: 7 words pending plus dout_valid=1, rflush=1 -> next cycle dout_valid=0, rempty=1, rlevel=0, and no rclken pulse.
REQ-044 Mid-run reset: rrst_n=0 during a streaming drain -> all outputs reach their reset values in the same cycle, without waiting for an rclk edge.
